// File: rtl/eth_tx_arbiter_pkg.sv
// eth_tx_arb_pkg: shared constants for the GMII transmit arbiter
package eth_tx_arb_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_IFG  = 2'd2;
    localparam logic PORT_ARP = 1'b0;
    localparam logic PORT_UDP = 1'b1;
    localparam int DEF_IFG_CYCLES     = 12;
    localparam int DEF_TIMEOUT_CYCLES = 2048;
endpackage

// File: rtl/eth_tx_arbiter_rr_arb2.sv
// eth_rr_arb2: combinational two-way picker, round-robin or fixed ARP priority on ties
module eth_rr_arb2
    import eth_tx_arb_pkg::*;
(
    input  logic       i_req_arp,
    input  logic       i_req_udp,
    input  logic       i_last_winner,
    input  logic       i_fixed_prio,
    output logic [1:0] o_winner
);
    logic w_pick_udp;
    // on a tie UDP wins only in round-robin mode when ARP won last
    always_comb begin
        w_pick_udp = (i_req_arp & i_req_udp) ? (!i_fixed_prio && i_last_winner == PORT_ARP) : i_req_udp;
        o_winner   = (i_req_arp | i_req_udp) ? (w_pick_udp ? 2'b10 : 2'b01) : 2'b00;
    end
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: grants the GMII TX path to ARP or UDP one frame at a time with an inter-frame gap
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int IFG_CYCLES     = DEF_IFG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FIXED_PRIO     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arp_tx_req,
    output logic       arp_tx_grant,
    input  logic       arp_tx_dv,
    input  logic [7:0] arp_txd,
    input  logic       arp_tx_done,
    input  logic       udp_tx_req,
    output logic       udp_tx_grant,
    input  logic       udp_tx_dv,
    input  logic [7:0] udp_txd,
    input  logic       udp_tx_done,
    output logic       gmii_tx_dv,
    output logic [7:0] gmii_txd,
    output logic       busy,
    output logic       timeout
);
    localparam int IW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES) : 1;
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]    r_state;
    logic          r_owner;
    logic          r_last;
    logic          r_dv;
    logic [7:0]    r_txd;
    logic          r_timeout;
    logic [IW-1:0] r_ifg;
    logic [TW-1:0] r_tmo;
    logic [1:0]    w_win;
    logic          w_dv;
    logic [7:0]    w_txd;
    logic          w_done;
    logic          w_tmo_hit;

    eth_rr_arb2 u_pick (
        .i_req_arp     (arp_tx_req),
        .i_req_udp     (udp_tx_req),
        .i_last_winner (r_last),
        .i_fixed_prio  (FIXED_PRIO != 0),
        .o_winner      (w_win)
    );

    // select only the current owner's inputs so the idle port cannot disturb the frame
    always_comb begin
        w_dv      = r_owner ? udp_tx_dv   : arp_tx_dv;
        w_txd     = r_owner ? udp_txd     : arp_txd;
        w_done    = r_owner ? udp_tx_done : arp_tx_done;
        w_tmo_hit = r_tmo == TW'(TIMEOUT_CYCLES - 1);
    end

    // arbitration FSM, gap/timeout counters and registered GMII outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= PORT_ARP;
            r_last    <= PORT_UDP;
            r_dv      <= 1'b0;
            r_txd     <= '0;
            r_timeout <= 1'b0;
            r_ifg     <= '0;
            r_tmo     <= '0;
        end else begin
            r_dv      <= 1'b0;
            r_txd     <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_win) begin
                        r_state <= ST_BUSY;
                        r_owner <= w_win[PORT_UDP];
                        r_last  <= w_win[PORT_UDP];
                        r_tmo   <= '0;
                    end
                end
                ST_BUSY: begin
                    r_dv  <= w_dv;
                    r_txd <= w_dv ? w_txd : 8'h00;
                    r_tmo <= r_tmo + 1'b1;
                    if (w_done || w_tmo_hit) begin
                        r_state   <= ST_IFG;
                        r_ifg     <= IW'(IFG_CYCLES - 1);
                        r_timeout <= !w_done;
                    end
                end
                default: begin
                    r_ifg <= r_ifg - 1'b1;
                    if (r_ifg == '0) r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign arp_tx_grant = r_state == ST_BUSY && r_owner == PORT_ARP;
    assign udp_tx_grant = r_state == ST_BUSY && r_owner == PORT_UDP;
    assign gmii_tx_dv   = r_dv;
    assign gmii_txd     = r_txd;
    assign busy         = r_state != ST_IDLE;
    assign timeout      = r_timeout;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed checks of arbitration, gap, timeout, isolation and reset
module tb_eth_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arp_req = 0, arp_dv = 0, arp_done = 0, udp_req = 0, udp_dv = 0, udp_done = 0;
    logic [7:0] arp_txd = 0, udp_txd = 0;
    logic       arp_gnt, udp_gnt, g_dv, busy, tmo;
    logic [7:0] g_txd;
    logic       p_arp_req = 0, p_udp_req = 0, p_arp_done = 0, p_udp_done = 0, z_dv = 0;
    logic [7:0] z_txd = 0;
    logic       p_arp_gnt, p_udp_gnt, p_dv, p_busy, p_tmo;
    logic [7:0] p_txd;
    int         n_chk = 0;
    int         n_err = 0;

    always #4 clk = ~clk;

    eth_tx_arbiter #(.IFG_CYCLES(12), .TIMEOUT_CYCLES(64), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .arp_tx_req(arp_req), .arp_tx_grant(arp_gnt), .arp_tx_dv(arp_dv), .arp_txd(arp_txd), .arp_tx_done(arp_done),
        .udp_tx_req(udp_req), .udp_tx_grant(udp_gnt), .udp_tx_dv(udp_dv), .udp_txd(udp_txd), .udp_tx_done(udp_done),
        .gmii_tx_dv(g_dv), .gmii_txd(g_txd), .busy(busy), .timeout(tmo)
    );

    eth_tx_arbiter #(.IFG_CYCLES(12), .TIMEOUT_CYCLES(64), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .arp_tx_req(p_arp_req), .arp_tx_grant(p_arp_gnt), .arp_tx_dv(z_dv), .arp_txd(z_txd), .arp_tx_done(p_arp_done),
        .udp_tx_req(p_udp_req), .udp_tx_grant(p_udp_gnt), .udp_tx_dv(z_dv), .udp_txd(z_txd), .udp_tx_done(p_udp_done),
        .gmii_tx_dv(p_dv), .gmii_txd(p_txd), .busy(p_busy), .timeout(p_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit p, output int n);
        n = 0;
        do begin
            tick;
            n++;
        end while (!(p ? udp_gnt : arp_gnt) && n < 200);
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick;
            n++;
        end
        chk("idle", busy, 0);
    endtask

    task automatic send_frame(input bit p, input int len, input logic [7:0] base);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            if (p) begin
                udp_req = 0; udp_dv = 1; udp_txd = b; udp_done = (i == len - 1);
            end else begin
                arp_req = 0; arp_dv = 1; arp_txd = b; arp_done = (i == len - 1);
            end
            tick;
            chk("frame_dv", g_dv, 1);
            chk("frame_txd", g_txd, b);
        end
        arp_dv = 0; arp_done = 0; udp_dv = 0; udp_done = 0;
        chk("rel_gnt", p ? udp_gnt : arp_gnt, 0);
    endtask

    initial begin
        int n;
        int pulses;
        tick;
        tick;
        chk("rst_arp_gnt", arp_gnt, 0);
        chk("rst_udp_gnt", udp_gnt, 0);
        chk("rst_gdv", g_dv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_fp_gnt", {p_arp_gnt, p_udp_gnt}, 0);
        rst = 0;
        tick;

        arp_req = 1;
        tick;
        chk("arp_only_gnt", arp_gnt, 1);
        chk("arp_only_udp", udp_gnt, 0);
        send_frame(0, 42, 8'h00);
        for (int i = 0; i < 11; i++) tick;
        chk("ifg_busy", busy, 1);
        chk("ifg_dv", g_dv, 0);
        tick;
        chk("ifg_end", busy, 0);

        rst = 1;
        tick;
        rst = 0;
        tick;
        arp_req = 1;
        udp_req = 1;
        tick;
        chk("tie1_arp", arp_gnt, 1);
        chk("tie1_udp", udp_gnt, 0);
        send_frame(0, 8, 8'h10);
        arp_req = 1;
        wait_gnt(1, n);
        chk("tie2_lat", n, 13);
        chk("tie2_arp", arp_gnt, 0);
        send_frame(1, 8, 8'h80);
        wait_gnt(0, n);
        chk("arp_next_lat", n, 13);
        send_frame(0, 4, 8'h30);
        wait_idle;

        p_arp_req = 1;
        p_udp_req = 1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                tick;
                n++;
            end while (!(p_arp_gnt | p_udp_gnt) && n < 200);
            chk("fp_lat", n, k == 0 ? 1 : 13);
            chk("fp_arp", p_arp_gnt, 1);
            chk("fp_udp", p_udp_gnt, 0);
            p_arp_done = 1;
            tick;
            p_arp_done = 0;
            chk("fp_rel", p_arp_gnt, 0);
        end
        p_arp_req = 0;
        p_udp_req = 0;

        udp_req = 1;
        tick;
        chk("to_gnt", udp_gnt, 1);
        udp_req = 0;
        n = 0;
        pulses = 0;
        while (udp_gnt && n < 200) begin
            n++;
            tick;
            if (tmo) pulses++;
        end
        chk("to_len", n, 64);
        chk("to_pulse_now", tmo, 1);
        for (int i = 0; i < 20; i++) begin
            tick;
            if (tmo) pulses++;
        end
        chk("to_pulses", pulses, 1);
        chk("to_idle", busy, 0);

        udp_req = 1;
        tick;
        chk("iso_gnt", udp_gnt, 1);
        udp_req = 0;
        udp_dv = 0;
        udp_txd = 8'h77;
        tick;
        chk("force_dv", g_dv, 0);
        chk("force_txd", g_txd, 0);
        for (int i = 0; i < 10; i++) begin
            udp_dv = 1; udp_txd = 8'h55; udp_done = (i == 9);
            arp_dv = 1; arp_txd = 8'hAA; arp_done = (i == 3);
            tick;
            chk("iso_txd", g_txd, 8'h55);
            chk("iso_udp_gnt", udp_gnt, i < 9 ? 1 : 0);
            chk("iso_arp_gnt", arp_gnt, 0);
        end
        udp_dv = 0; udp_done = 0; arp_done = 0;
        tick;
        chk("iso_ifg_dv", g_dv, 0);
        arp_dv = 0;
        wait_idle;

        arp_req = 1;
        tick;
        arp_req = 0;
        for (int i = 0; i < 20; i++) begin
            arp_dv = 1;
            arp_txd = 8'(i);
            tick;
        end
        chk("mid_dv", g_dv, 1);
        rst = 1;
        #1;
        chk("arst_dv", g_dv, 0);
        chk("arst_txd", g_txd, 0);
        chk("arst_gnt", arp_gnt, 0);
        chk("arst_busy", busy, 0);
        arp_dv = 0;
        tick;
        rst = 0;
        tick;
        arp_req = 1;
        tick;
        chk("post_rst_gnt", arp_gnt, 1);
        send_frame(0, 4, 8'h40);
        wait_idle;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
